// File: rtl/stream_demux_burst_pkg.sv
// Shared types for the stream_demux burst-select front end.
// Imported by the control stage and its wrapper.
package stream_demux_burst_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } burst_state_e;

endpackage

// File: rtl/stream_demux_burst_sel.sv
// Command-driven burst router in front of stream_demux.
// Holds the select steady for a whole burst of data beats.
module stream_demux_burst_sel
  import stream_demux_burst_pkg::*;
#(
  parameter int unsigned N_OUP      = 32'd4,
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned MAX_BURST  = 32'd16,
  parameter int unsigned LOG_N_OUP  = (N_OUP > 1) ? $clog2(N_OUP) : 1,
  parameter int unsigned LEN_WIDTH  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [LOG_N_OUP-1:0]  cmd_sel_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  inp_valid_i,
  output logic                  inp_ready_o,
  input  logic [DATA_WIDTH-1:0] inp_data_i,
  output logic                  oup_valid_o,
  input  logic                  oup_ready_i,
  output logic [DATA_WIDTH-1:0] oup_data_o,
  output logic [LOG_N_OUP-1:0]  oup_sel_o,
  output logic                  oup_last_o,
  output logic                  busy_o
);

  burst_state_e         state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LOG_N_OUP-1:0] sel_q, sel_d;
  logic                 last;
  logic                 beat;

  assign last = (cnt_q == '0);
  assign beat = inp_valid_i & oup_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    cmd_ready_o = 1'b0;
    inp_ready_o = 1'b0;
    oup_valid_o = 1'b0;
    oup_last_o  = 1'b0;
    busy_o      = 1'b0;
    oup_sel_o   = sel_q;
    oup_data_o  = inp_data_i;
    if (rst_i) begin
      oup_sel_o = '0;
      state_d   = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_ready_o = 1'b1;
          if (cmd_valid_i) begin
            sel_d   = cmd_sel_i;
            cnt_d   = cmd_len_i;
            state_d = BURST;
          end
        end
        BURST: begin
          busy_o      = 1'b1;
          oup_valid_o = inp_valid_i;
          inp_ready_o = oup_ready_i;
          oup_last_o  = last;
          if (beat) begin
            if (!last) begin
              cnt_d = cnt_q - 1'b1;
            end else begin
              // Final beat frees the slot for a back-to-back command.
              cmd_ready_o = 1'b1;
              if (cmd_valid_i) begin
                sel_d = cmd_sel_i;
                cnt_d = cmd_len_i;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  a_sel_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (oup_valid_o && !oup_ready_i) |=> $stable(oup_sel_o));

  a_idle_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == IDLE) |-> (!inp_ready_o && !oup_valid_o));

  a_last_cnt: assert property (@(posedge clk_i) disable iff (rst_i)
    oup_last_o |-> (cnt_q == '0));

  a_sel_range: assert property (@(posedge clk_i) disable iff (rst_i)
    (cmd_valid_i && cmd_ready_o) |-> (32'(cmd_sel_i) < N_OUP))
    else $error("cmd_sel_i out of range: %0d", cmd_sel_i);

endmodule
